// File: rtl/cva6_instr_sequencer.sv
// Program sequencer feeding the instruction port of cva6_processor_shim: a small writable
// program buffer issued in order under valid/ready, with a one-cycle bubble after each load/store.
module cva6_instr_sequencer #(
  parameter int unsigned PROG_DEPTH = 4,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned PC_W       = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               prog_we_i,
  input  logic [PC_W-2:0]    prog_waddr_i,
  input  logic [INSTR_W-1:0] prog_wdata_i,
  input  logic [PC_W-1:0]    prog_len_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    memop_cnt_o
);

  localparam int unsigned     AW        = $clog2(PROG_DEPTH);
  localparam logic [PC_W-1:0] DEPTH_PC  = PC_W'(PROG_DEPTH);
  localparam logic [6:0]      OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]      OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUBBLE,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     len_q, len_d;
  logic [PC_W-1:0]     memop_q, memop_d;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     start_len;
  logic [INSTR_W-1:0]  prog_mem [PROG_DEPTH];
  logic [INSTR_W-1:0]  cur_instr;
  logic                is_memop;
  logic                transfer;

  // NOTE: the program buffer has no reset; clearing a memory array costs a mux per bit for no benefit.
  always_ff @(posedge clk_i) begin
    if (prog_we_i && (state_q == IDLE)) begin
      prog_mem[prog_waddr_i] <= prog_wdata_i;
    end
  end

  assign cur_instr = prog_mem[pc_q[AW-1:0]];
  assign is_memop  = (cur_instr[6:0] == OPC_LOAD) || (cur_instr[6:0] == OPC_STORE);
  assign transfer  = instr_valid_o && instr_ready_i;
  assign pc_inc    = pc_q + PC_W'(1);
  assign start_len = (prog_len_i > DEPTH_PC) ? DEPTH_PC : prog_len_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    memop_d = memop_q;
    if (abort_i) begin
      // A transfer in this cycle is accepted by the shim but not counted here.
      state_d = IDLE;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            len_d   = start_len;
            pc_d    = '0;
            memop_d = '0;
            state_d = (start_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (transfer) begin
            pc_d = pc_inc;
            if (is_memop) begin
              memop_d = memop_q + PC_W'(1);
            end
            // The final entry ends the run even if it is a memory op: no trailing bubble.
            if (pc_inc == len_q) begin
              state_d = DONE;
            end else if (is_memop) begin
              state_d = BUBBLE;
            end else begin
              state_d = ISSUE;
            end
          end
        end
        BUBBLE:  state_d = ISSUE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      memop_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      memop_q <= memop_d;
    end
  end

  assign instr_valid_o = (state_q == ISSUE);
  assign instr_o       = (state_q == ISSUE) ? cur_instr : '0;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign pc_o          = pc_q;
  assign memop_cnt_o   = memop_q;

`ifndef SYNTHESIS
  stall_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_valid_o && !instr_ready_i && !abort_i) |=>
      (instr_valid_o && $stable(instr_o) && $stable(pc_o)));

  len_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    len_q <= DEPTH_PC);
`endif

endmodule

// File: tb/tb_cva6_instr_sequencer.sv
// Directed bench for cva6_instr_sequencer: a per-cycle vector table plus hand-written
// sequences for asynchronous reset mid-bubble, writes while busy and a trailing memory op.
module tb_cva6_instr_sequencer;

  localparam logic [31:0] LW  = 32'h0000_2103;
  localparam logic [31:0] SW  = 32'h0020_2223;
  localparam logic [31:0] AD5 = 32'h0050_0093;
  localparam logic [31:0] A1  = 32'h0010_0093;
  localparam logic [31:0] A2  = 32'h0020_0093;
  localparam logic [31:0] A3  = 32'h0030_0093;
  localparam logic [31:0] A4  = 32'h0040_0093;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        prog_we_i = 1'b0;
  logic [1:0]  prog_waddr_i = '0;
  logic [31:0] prog_wdata_i = '0;
  logic [2:0]  prog_len_i = '0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  pc_o;
  logic [2:0]  memop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cva6_instr_sequencer #(.PROG_DEPTH(4), .INSTR_W(32), .PC_W(3)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .prog_we_i     (prog_we_i),
    .prog_waddr_i  (prog_waddr_i),
    .prog_wdata_i  (prog_wdata_i),
    .prog_len_i    (prog_len_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pc_o          (pc_o),
    .memop_cnt_o   (memop_cnt_o)
  );

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  len;
    logic        start;
    logic        abort;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [2:0]  e_pc;
    logic [2:0]  e_memop;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic we, input logic [1:0] waddr, input logic [31:0] wdata,
                             input logic [2:0] len, input logic start, input logic abort,
                             input logic ready, input logic e_valid, input logic [31:0] e_instr,
                             input logic [2:0] e_pc, input logic [2:0] e_memop,
                             input logic e_done, input logic e_busy);
    vec_t r;
    r.we = we; r.waddr = waddr; r.wdata = wdata; r.len = len; r.start = start;
    r.abort = abort; r.ready = ready; r.e_valid = e_valid; r.e_instr = e_instr;
    r.e_pc = e_pc; r.e_memop = e_memop; r.e_done = e_done; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_valid, input logic [31:0] e_instr,
                               input logic [2:0] e_pc, input logic [2:0] e_memop,
                               input logic e_done, input logic e_busy);
    check({tag, " valid"}, 32'(instr_valid_o), 32'(e_valid));
    check({tag, " instr"}, instr_o, e_instr);
    check({tag, " pc"},    32'(pc_o), 32'(e_pc));
    check({tag, " memop"}, 32'(memop_cnt_o), 32'(e_memop));
    check({tag, " done"},  32'(done_o), 32'(e_done));
    check({tag, " busy"},  32'(busy_o), 32'(e_busy));
  endtask

  // Drive one cycle's inputs just after the falling edge, check outputs, then cross the rising edge.
  task automatic step(input string tag, input vec_t r);
    prog_we_i     = r.we;
    prog_waddr_i  = r.waddr;
    prog_wdata_i  = r.wdata;
    prog_len_i    = r.len;
    start_i       = r.start;
    abort_i       = r.abort;
    instr_ready_i = r.ready;
    #1;
    check_outputs(tag, r.e_valid, r.e_instr, r.e_pc, r.e_memop, r.e_done, r.e_busy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // T2: write+start in the same cycle, then LW/SW/LW/ADDI with bubbles after memory ops.
    vecs.push_back(v(1, 0, LW,  0, 0, 0, 1,  0, 0,   0, 0, 0, 0));
    vecs.push_back(v(1, 1, SW,  0, 0, 0, 1,  0, 0,   0, 0, 0, 0));
    vecs.push_back(v(1, 2, LW,  0, 0, 0, 1,  0, 0,   0, 0, 0, 0));
    vecs.push_back(v(1, 3, AD5, 4, 1, 0, 1,  0, 0,   0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, LW,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   1, 1, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, SW,  1, 1, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   2, 2, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, LW,  2, 2, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   3, 3, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, AD5, 3, 3, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   4, 3, 1, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   4, 3, 0, 0));
    // T1: four ALU ops back to back; prog_len_i=7 is clamped to 4.
    vecs.push_back(v(1, 0, A1,  0, 0, 0, 1,  0, 0,   4, 3, 0, 0));
    vecs.push_back(v(1, 1, A2,  0, 0, 0, 1,  0, 0,   4, 3, 0, 0));
    vecs.push_back(v(1, 2, A3,  0, 0, 0, 1,  0, 0,   4, 3, 0, 0));
    vecs.push_back(v(1, 3, A4,  0, 0, 0, 1,  0, 0,   4, 3, 0, 0));
    vecs.push_back(v(0, 0, 0,   7, 1, 0, 1,  0, 0,   4, 3, 0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A1,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A2,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A3,  2, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A4,  3, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   4, 0, 1, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   4, 0, 0, 0));
    // T3: len=3, two stall cycles on entry 1; a stray start while busy is ignored.
    vecs.push_back(v(0, 0, 0,   3, 1, 0, 0,  0, 0,   4, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A1,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   1, 1, 0, 0,  1, A2,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 0,  1, A2,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A2,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A3,  2, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   3, 0, 1, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   3, 0, 0, 0));
    // T4: zero-length program.
    vecs.push_back(v(0, 0, 0,   0, 1, 0, 1,  0, 0,   3, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   0, 0, 1, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   0, 0, 0, 0));
    // T5: abort with a transfer at pc=2, restart, then abort while stalled.
    vecs.push_back(v(0, 0, 0,   4, 1, 0, 1,  0, 0,   0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A1,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A2,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 1, 1,  1, A3,  2, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   4, 1, 0, 1,  0, 0,   0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  1, A1,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 1, 0,  1, A2,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0,   0, 0, 0, 1,  0, 0,   0, 0, 0, 0));

    #1;
    check_outputs("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("row%0d", i), vecs[i]);
    end

    // T6: LW at entry 0, run len=2; a write to entry 1 while busy must be dropped.
    step("t6 wr",    v(1, 0, LW,  0, 0, 0, 1,  0, 0,  0, 0, 0, 0));
    step("t6 start", v(0, 0, 0,   2, 1, 0, 1,  0, 0,  0, 0, 0, 0));
    step("t6 issue", v(1, 1, BAD, 0, 0, 0, 1,  1, LW, 0, 0, 0, 1));
    prog_we_i = 1'b0;
    #1;
    check_outputs("t6 bubble", 0, 0, 1, 1, 0, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_outputs("t6 async rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    step("t6 rs start", v(0, 0, 0, 2, 1, 0, 1,  0, 0,  0, 0, 0, 0));
    step("t6 rs e0",    v(0, 0, 0, 0, 0, 0, 1,  1, LW, 0, 0, 0, 1));
    step("t6 rs bub",   v(0, 0, 0, 0, 0, 0, 1,  0, 0,  1, 1, 0, 1));
    step("t6 rs e1",    v(0, 0, 0, 0, 0, 0, 1,  1, A2, 1, 1, 0, 1));
    step("t6 rs done",  v(0, 0, 0, 0, 0, 0, 1,  0, 0,  2, 1, 1, 1));
    step("t6 rs idle",  v(0, 0, 0, 0, 0, 0, 1,  0, 0,  2, 1, 0, 0));

    // Last entry is a store: DONE follows directly, no bubble.
    step("tail wr",    v(1, 1, SW, 0, 0, 0, 1,  0, 0,  2, 1, 0, 0));
    step("tail start", v(0, 0, 0,  2, 1, 0, 1,  0, 0,  2, 1, 0, 0));
    step("tail e0",    v(0, 0, 0,  0, 0, 0, 1,  1, LW, 0, 0, 0, 1));
    step("tail bub",   v(0, 0, 0,  0, 0, 0, 1,  0, 0,  1, 1, 0, 1));
    step("tail e1",    v(0, 0, 0,  0, 0, 0, 1,  1, SW, 1, 1, 0, 1));
    step("tail done",  v(0, 0, 0,  0, 0, 0, 1,  0, 0,  2, 2, 1, 1));
    step("tail idle",  v(0, 0, 0,  0, 0, 0, 1,  0, 0,  2, 2, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
